lut_cfg_loader: RTL
===================

Name: lut_cfg_loader

Overview:
- Configuration controller for a bank of N_LUT fpga_4lut cells.
- Accepts a serial configuration bitstream through a valid/ready handshake and assembles 16-bit truth-table words.
- Drives each LUT's data_in_i/data_we_i with a setup/write/hold sequence, which is safe for the level-sensitive latches inside the LUT.
- Sits between the chip config port and the LUT array; one shared data bus, one write-enable per LUT.

Parameters:
- N_LUT, 4, number of LUTs in the bank (1..64).
- IDX_W, max(1,$clog2(N_LUT)), width of the LUT index (derived; do not override).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous reset, active-high
- start_i  in  1  begin a full-bank load; sampled in IDLE only
- abort_i  in  1  cancel the load in progress; return to IDLE
- cfg_valid_i  in  1  cfg_bit_i is valid this cycle
- cfg_bit_i  in  1  serial configuration bit, MSB of each word first
- cfg_ready_o  out  1  loader accepts a bit this cycle
- lut_data_o  out  16  shared truth-table word to all LUT data_in_i
- lut_we_o  out  N_LUT  one-hot write enable, bit k to LUT k data_we_i
- lut_idx_o  out  IDX_W  index of the LUT currently being loaded
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when the last LUT has been written

Behaviour:
- All outputs are registered.
- Reset values: cfg_ready_o=0, lut_data_o=0, lut_we_o=0, lut_idx_o=0, busy_o=0, done_o=0. The FSM resets to IDLE and the bit counter to 0.
- FSM states: IDLE, SHIFT, SETUP, WRITE, HOLD, DONE.
- IDLE:
  - start_i=1 -> SHIFT; lut_idx_o=0; bit counter=0.
  - Otherwise stay in IDLE.
- SHIFT:
  - cfg_ready_o=1.
  - A bit is accepted only when cfg_valid_i && cfg_ready_o. It is shifted in at the LSB: shreg <= {shreg[14:0],cfg_bit_i}, so the first bit received ends up in bit 15. The 4-bit counter increments on each accepted bit.
  - When the 16th bit is accepted (counter==15), go to SETUP.
  - Valid gaps are allowed; the state and counter hold during them.
- SETUP:
  - lut_data_o <= shreg; lut_we_o=0; cfg_ready_o=0.
  - Lasts one cycle. Gives data setup before the latch opens.
- WRITE:
  - lut_we_o[lut_idx_o]=1; all other bits 0.
  - Lasts exactly one cycle; lut_data_o is stable.
- HOLD:
  - lut_we_o=0 and lut_data_o unchanged for one cycle (latch hold time).
  - If lut_idx_o==N_LUT-1 -> DONE.
  - Otherwise lut_idx_o++, bit counter=0, -> SHIFT.
- DONE:
  - done_o=1 for one cycle, then -> IDLE. busy_o=0 from the IDLE cycle onward.
- Timing:
  - Load latency per LUT is 16 accepted bits + 3 cycles.
  - Minimum full-bank time is N_LUT*19 + 1 cycles from the start_i sample to the done_o pulse.
- start_i while busy_o=1 is ignored; there is no queueing.
- abort_i has priority over all transitions in any non-IDLE state:
  - Next cycle: IDLE, lut_we_o=0, cfg_ready_o=0, no done_o.
  - lut_data_o keeps its last value. LUTs already written keep their contents.
- reset_i has priority over abort_i and start_i. reset_i during WRITE must force lut_we_o=0 on the next edge.
- lut_we_o is never multi-hot and is never high outside WRITE.
- Simultaneous start_i and abort_i in IDLE: abort wins and the FSM stays in IDLE.
- N_LUT=1: HOLD always goes to DONE; lut_idx_o stays 0.

Decomposition:
- Shared package lut_cfg_pkg:
  - FSM state enum.
  - LUT_W=16.
  - Constant for cycles per LUT (19).
- Sub-module lut_cfg_shreg: 16-bit shift register plus 4-bit bit counter with a word_full flag. The FSM and index logic stay in the top.

Test Plan:
- Reset, then start_i with N_LUT=4. Stream words 0x8000, 0x0001, 0xA5A5, 0xFFFF with cfg_valid_i held high -> each LUT sees lut_we_o one-hot 0001/0010/0100/1000 in turn with matching lut_data_o. done_o pulses exactly 77 cycles after start_i is sampled.
- Same words with cfg_valid_i low on every other cycle -> identical LUT contents. The count of cfg_ready_o&&cfg_valid_i equals 64. No write occurs before the 16th accepted bit.
- abort_i asserted after 9 bits of LUT 2 -> IDLE next cycle and lut_we_o never reaches 0100. LUTs 0 and 1 keep their values. No done_o. A fresh start_i then reloads from LUT 0.
- start_i pulsed during SHIFT and during WRITE -> no effect. lut_idx_o and the bit counter are unchanged.
- reset_i asserted in the WRITE cycle of LUT 1 -> all outputs at reset values next cycle; lut_we_o=0.
- N_LUT=1 build with word 0x6996 (XOR4) -> single WRITE pulse, done_o after 20 cycles. The cfg_4lut output then matches XOR of in_i for all 16 inputs.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared types and constants for the LUT bank configuration loader.
// Holds the FSM encoding and the truth-table word geometry.
package lut_cfg_pkg;

    localparam int LUT_W       = 16;
    localparam int CNT_W       = 4;
    localparam int CYC_PER_LUT = 19;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_SETUP = 3'd2,
        ST_WRITE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/lut_cfg_shreg.sv
// Serial-to-parallel assembler: 16-bit MSB-first shift register and bit counter.
// word_next_o already contains the bit being accepted, so the word can be captured on the 16th bit.
module lut_cfg_shreg
    import lut_cfg_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [LUT_W-1:0] word_next_o,
    output logic             word_full_o
);

    logic [LUT_W-1:0] shreg_r;
    logic [CNT_W-1:0] count_r;

    // Word after the current bit is shifted in, and last-bit detection.
    always_comb begin
        word_next_o = {shreg_r[LUT_W-2:0], bit_i};
        if (shift_i && (count_r == 4'd15)) begin
            word_full_o = 1'b1;
        end else begin
            word_full_o = 1'b0;
        end
    end

    // Shift register and accepted-bit counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shreg_r <= 16'h0000;
            count_r <= 4'd0;
        end else if (clr_i) begin
            count_r <= 4'd0;
        end else if (shift_i) begin
            shreg_r <= word_next_o;
            count_r <= count_r + 4'd1;
        end
    end

endmodule

// File: rtl/lut_cfg_loader.sv
// Configuration loader for a bank of 4-input LUTs: assembles serial words and
// writes each LUT with a setup/write/hold sequence on a shared data bus.
module lut_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter int N_LUT = 4,
    parameter int IDX_W = (N_LUT > 1) ? $clog2(N_LUT) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             cfg_valid_i,
    input  logic             cfg_bit_i,
    output logic             cfg_ready_o,
    output logic [LUT_W-1:0] lut_data_o,
    output logic [N_LUT-1:0] lut_we_o,
    output logic [IDX_W-1:0] lut_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t           state_r;
    state_t           next_state_s;
    logic             ready_r;
    logic [LUT_W-1:0] data_r;
    logic [N_LUT-1:0] we_r;
    logic [IDX_W-1:0] idx_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             clr_cnt_s;
    logic             load_data_s;
    logic             idx_clr_s;
    logic             idx_inc_s;
    logic             last_lut_s;
    logic [LUT_W-1:0] word_next_s;
    logic             word_full_s;
    logic [N_LUT-1:0] we_onehot_s;

    assign cfg_ready_o = ready_r;
    assign lut_data_o  = data_r;
    assign lut_we_o    = we_r;
    assign lut_idx_o   = idx_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

    // ready_r is high exactly in SHIFT, so it doubles as the state qualifier.
    assign accept_s   = cfg_valid_i & ready_r;
    assign last_lut_s = (idx_r == IDX_W'(N_LUT - 1));

    lut_cfg_shreg u_shreg (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clr_i       (clr_cnt_s),
        .shift_i     (accept_s),
        .bit_i       (cfg_bit_i),
        .word_next_o (word_next_s),
        .word_full_o (word_full_s)
    );

    // Write-enable pattern for the LUT currently addressed.
    always_comb begin
        we_onehot_s        = '0;
        we_onehot_s[idx_r] = 1'b1;
    end

    // Next-state and control strobes; abort overrides every non-idle transition.
    always_comb begin
        next_state_s = state_r;
        clr_cnt_s    = 1'b0;
        load_data_s  = 1'b0;
        idx_clr_s    = 1'b0;
        idx_inc_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    next_state_s = ST_SHIFT;
                    clr_cnt_s    = 1'b1;
                    idx_clr_s    = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (abort_i) begin
                    next_state_s = ST_IDLE;
                end else if (word_full_s) begin
                    next_state_s = ST_SETUP;
                    load_data_s  = 1'b1;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_SETUP: begin
                if (abort_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort_i) begin
                    next_state_s = ST_IDLE;
                end else if (last_lut_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                    idx_inc_s    = 1'b1;
                    clr_cnt_s    = 1'b1;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register and outputs, registered from the next state so they align with it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            data_r  <= 16'h0000;
            we_r    <= '0;
            idx_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            ready_r <= (next_state_s == ST_SHIFT);
            we_r    <= (next_state_s == ST_WRITE) ? we_onehot_s : '0;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
            if (load_data_s) begin
                data_r <= word_next_s;
            end
            if (idx_clr_s) begin
                idx_r <= '0;
            end else if (idx_inc_s) begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end
    end

endmodule
